// File: rtl/impact_link_pkg.sv
// impact_link_pkg
// Shared definitions for the IMPACT edge-link transmitter: beat geometry,
// the transmit FSM state type, the beat index type and a byte-select helper.
package impact_link_pkg;

    localparam int BEAT_W         = 8;
    localparam int BEATS_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
    } link_tx_state_t;

    typedef logic [1:0] beat_idx_t;

    // Beat b of a word; beat 0 is the least significant byte.
    function automatic logic [BEAT_W-1:0] beat_of(
        input logic [BEAT_W*BEATS_PER_WORD-1:0] w,
        input beat_idx_t                        b
    );
        return w[b*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/impact_link_fifo.sv
// impact_link_fifo
// Synchronous word FIFO between the core-side push interface and the link
// serializer. The caller never pushes when level == DEPTH and never pops when
// level == 0. Read data is presented combinationally from the read pointer.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write strobe and word
//   pop, dout   read strobe and head-of-queue word
//   level       occupancy, 0..DEPTH
module impact_link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide which
    // entries are valid, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/impact_link_tx.sv
// impact_link_tx
// Transmit end of the IMPACT inter-chip edge link. Words from the core are
// queued in a FIFO and sent as four 8-bit beats, LS byte first, each beat
// using a two-phase (toggle) req/ack handshake with the neighbouring head.
//
// Optional feature: define IMPACT_LINK_PARITY_EN to add link_par_o, the even
// parity of link_data_o, registered together with the data.
//
// Ports:
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   word_i, word_valid_i        core word and its valid
//   word_ready_o                FIFO has room (level < DEPTH)
//   link_data_o, link_first_o   current beat and "beat 0" marker, to pads
//   link_req_o                  toggles once per beat
//   link_ack_i                  receiver ack toggle, asynchronous
//   link_par_o                  beat parity (IMPACT_LINK_PARITY_EN only)
//   busy_o                      FSM not idle
//   level_o                     FIFO occupancy
module impact_link_tx #(
    parameter int DEPTH  = 4,
    parameter int BEAT_W = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic [31:0]              word_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    output logic [BEAT_W-1:0]        link_data_o,
    output logic                     link_first_o,
    output logic                     link_req_o,
    input  logic                     link_ack_i,
`ifdef IMPACT_LINK_PARITY_EN
    output logic                     link_par_o,
`endif
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    import impact_link_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    link_tx_state_t state;
    link_tx_state_t state_next;
    beat_idx_t      beat;
    logic [31:0]    shreg;
    logic [1:0]     ack_sync;
    logic           ack_s;
    logic           push;
    logic           fifo_pop;
    logic           fifo_empty;
    logic [31:0]    fifo_dout;
    logic [LW-1:0]  fifo_level;

    impact_link_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .push  (push),
        .din   (word_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (fifo_level)
    );

    assign word_ready_o = (fifo_level < LW'(DEPTH));
    assign push         = word_valid_i && word_ready_o;
    assign fifo_empty   = (fifo_level == '0);
    assign level_o      = fifo_level;
    assign busy_o       = (state != IDLE);

    // The ack comes from another chip's clock domain.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) ack_sync <= '0;
        else           ack_sync <= {ack_sync[0], link_ack_i};
    end
    assign ack_s = ack_sync[1];

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: begin
                // Beat accepted once the synchronized ack catches up with req.
                if (ack_s == link_req_o) begin
                    if (beat != beat_idx_t'(BEATS_PER_WORD - 1)) begin
                        state_next = LOAD;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word without idling.
                        fifo_pop   = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data and first are only written in LOAD, so they stay stable through
    // SEND and WAIT and hold their last value in IDLE.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            shreg        <= '0;
            link_data_o  <= '0;
            link_first_o <= 1'b0;
            link_req_o   <= 1'b0;
        end else begin
            state <= state_next;
            if (fifo_pop) begin
                shreg <= fifo_dout;
                beat  <= '0;
            end else if (state == WAIT && state_next == LOAD) begin
                beat <= beat + 1'b1;
            end
            if (state == LOAD) begin
                link_data_o  <= beat_of(shreg, beat);
                link_first_o <= (beat == '0);
            end
            if (state == SEND) link_req_o <= ~link_req_o;
        end
    end

`ifdef IMPACT_LINK_PARITY_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)          link_par_o <= 1'b0;
        else if (state == LOAD) link_par_o <= ^beat_of(shreg, beat);
    end
`endif

endmodule

// File: tb/tb_impact_link_tx.sv
// tb_impact_link_tx
// Self-checking bench for impact_link_tx. Every accepted word is expanded
// into four expected beats (LS byte first, first flag on beat 0) in a queue;
// a monitor compares each req toggle against the head of that queue. The ack
// is either looped back from req through a flop pipeline or driven by hand.
module tb_impact_link_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [7:0]  link_data;
    logic        link_first;
    logic        link_req;
    logic        link_ack;
`ifdef IMPACT_LINK_PARITY_EN
    logic        link_par;
`endif
    logic        busy;
    logic [2:0]  level;

    impact_link_tx #(.DEPTH(4), .BEAT_W(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .word_i       (word),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .link_data_o  (link_data),
        .link_first_o (link_first),
        .link_req_o   (link_req),
        .link_ack_i   (link_ack),
`ifdef IMPACT_LINK_PARITY_EN
        .link_par_o   (link_par),
`endif
        .busy_o       (busy),
        .level_o      (level)
    );

    always #5 clk = ~clk;

    // Receiver model: ack follows req through ack_dly+1 flops, or is manual.
    logic [7:0] ack_pipe;
    int         ack_dly = 2;
    logic       ack_sel = 1'b0;
    logic       ack_man = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_pipe <= '0;
        else        ack_pipe <= {ack_pipe[6:0], link_req};
    end
    assign link_ack = ack_sel ? ack_man : ack_pipe[ack_dly];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       first;
    } beat_t;

    beat_t exp_q[$];

    function automatic void enqueue(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back('{w[8*b +: 8], (b == 0)});
    endfunction

    // Monitor: sample on the falling edge, one comparison set per req toggle.
    int         cyc = 0;
    int         tog_cnt = 0;
    int         tog_t[$];
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = '0;
    beat_t      mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_req  = 1'b0;
            prev_data = '0;
        end else begin
            if (link_req !== prev_req) begin
                tog_cnt++;
                tog_t.push_back(cyc);
                check("data_setup", link_data, prev_data);
                if (exp_q.size() == 0) begin
                    check("beat_extra", link_data, 32'hxxxx_xxxx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", link_data, mon_e.data);
                    check("beat_first", link_first, mon_e.first);
`ifdef IMPACT_LINK_PARITY_EN
                    check("beat_par", link_par, ^mon_e.data);
`endif
                end
            end
            prev_req  = link_req;
            prev_data = link_data;
        end
    end

    // Called just after a falling edge; returns just after a falling edge.
    task automatic push_word(input logic [31:0] w, input int budget, output bit acc);
        acc        = 1'b0;
        word       = w;
        word_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (word_ready) begin
                acc = 1'b1;
                enqueue(w);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && exp_q.size() == 0 && level == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, done, 1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        word_valid = 1'b0;
        ack_sel    = 1'b0;
        ack_man    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready"}, word_ready, 1);
        check({pfx, "_data"},  link_data, 0);
        check({pfx, "_first"}, link_first, 0);
        check({pfx, "_req"},   link_req, 0);
        check({pfx, "_busy"},  busy, 0);
        check({pfx, "_level"}, level, 0);
`ifdef IMPACT_LINK_PARITY_EN
        check({pfx, "_par"},   link_par, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acc;
        bit          done;
        int          base;
        logic [31:0] w;
        logic [31:0] w3;

        // ---- reset values ----
        do_reset();
        check_reset_values("rst");

        // ---- single word, ack looped through 3 flops ----
        base = tog_cnt;
        push_word(32'hA1B2C3D4, 5, acc);
        check("s1_push", acc, 1);
        @(negedge clk);
        @(negedge clk);
        check("s1_data_edge2", link_data, 8'hD4);
        check("s1_first_edge2", link_first, 1);
        check("s1_req_edge2", link_req, 0);
        @(negedge clk);
        check("s1_req_edge3", link_req, 1);
        wait_idle("s1_drain", 200);
        check("s1_toggles", tog_cnt - base, 4);
        check("s1_req_end", link_req, 0);

        // ---- ack held: fill the FIFO, sixth word stalls ----
        ack_man = link_ack;
        ack_sel = 1'b1;
        base    = tog_cnt;
        for (int i = 0; i < 5; i++) begin
            push_word($urandom, 5, acc);
            check("s2_push", acc, 1);
        end
        w = $urandom;
        push_word(w, 10, acc);
        check("s2_stall", acc, 0);
        check("s2_level_full", level, 4);
        check("s2_ready_low", word_ready, 0);
        check("s2_busy", busy, 1);
        check("s2_one_beat", tog_cnt - base, 1);

        // ---- release ack: remaining beats stream out ----
        tog_t.delete();
        ack_sel = 1'b0;
        push_word(w, 400, acc);
        check("s2_late_push", acc, 1);
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s2_all_beats", done, 1);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (link_ack == link_req) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s2_last_ack", done, 1);
        @(negedge clk);
        @(negedge clk);
        check("s2_busy_hold", busy, 1);
        @(negedge clk);
        check("s2_busy_fall", busy, 0);
        check("s2_toggles", tog_t.size(), 23);
        for (int i = 1; i + 1 < tog_t.size(); i++)
            check("s2_gap", tog_t[i+1] - tog_t[i], tog_t[1] - tog_t[0]);

        // ---- push and pop in the same cycle at level 2 ----
        ack_man = link_req;
        ack_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_word($urandom, 5, acc);
            check("s3_push", acc, 1);
        end
        w3 = $urandom;
        for (int b = 0; b < 4; b++) begin
            done = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (link_req != ack_man) begin
                    done = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("s3_beat_sent", done, 1);
            ack_man = link_req;
            if (b == 3) begin
                // Two sync flops, then the WAIT decision pops on the next edge.
                @(negedge clk);
                @(negedge clk);
                check("s3_level_pre", level, 2);
                check("s3_ready_pre", word_ready, 1);
                word       = w3;
                word_valid = 1'b1;
                enqueue(w3);
                @(negedge clk);
                word_valid = 1'b0;
                check("s3_level_same", level, 2);
                @(negedge clk);
                check("s3_next_first", link_first, 1);
            end
        end
        ack_sel = 1'b0;
        wait_idle("s3_drain", 500);

        // ---- reset during beat 2 ----
        base = tog_cnt;
        push_word($urandom, 5, acc);
        check("s4_push", acc, 1);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tog_cnt - base >= 3) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("s4_beat2", done, 1);
        check("s4_req_before", link_req, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("s4");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = tog_cnt;
        push_word(32'h55667788, 5, acc);
        check("s4_push_after", acc, 1);
        @(negedge clk);
        @(negedge clk);
        check("s4_data0", link_data, 8'h88);
        check("s4_first0", link_first, 1);
        check("s4_req_low", link_req, 0);
        @(negedge clk);
        check("s4_req_rise", link_req, 1);
        wait_idle("s4_drain", 200);
        check("s4_toggles", tog_cnt - base, 4);

        // ---- randomized traffic with random ack latency ----
        for (int ph = 0; ph < 2; ph++) begin
            ack_dly = $urandom_range(0, 4);
            for (int i = 0; i < 15; i++) begin
                if (ph == 0 && i == 0)      w = 32'h0000_00FF;
                else if (ph == 0 && i == 1) w = 32'h0000_0001;
                else                        w = $urandom;
                push_word(w, 400, acc);
                check("s5_push", acc, 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle("s5_drain", 3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
